rsflag_bank: RTL and testbench

//  Parametrised bank of WIDTH independent set/reset flags sharing one clock.

---
 rtl/rsflag_bank.sv | 169 ++++++++++++++++
 tb/tb_rsflag_bank.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/rsflag_bank.sv
// rsflag_bank: WIDTH independent set/reset flags with collision policy, optional
// auto-clear hold timer, rise pulses and summary outputs. Optional: RSFLAG_BANK_ERR_EN.
module rsflag_bank #(
  parameter int unsigned           WIDTH          = 8,
  parameter logic [WIDTH-1:0]      INIT_VALUE     = '0,
  parameter int                    COLLISION_MODE = 0,
  parameter int unsigned           HOLD_CYCLES    = 0,
  parameter int unsigned           IDX_W          = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             init,
  input  logic [WIDTH-1:0] s,
  input  logic [WIDTH-1:0] r,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] rise,
  output logic             any_q,
  output logic [IDX_W-1:0] first_idx
`ifdef RSFLAG_BANK_ERR_EN
  ,
  output logic             err
`endif
);

  if (COLLISION_MODE < 0 || COLLISION_MODE > 3) begin : g_bad_mode
    $error("rsflag_bank: COLLISION_MODE must be 0..3");
  end
  if (WIDTH < 1 || WIDTH > 32) begin : g_bad_width
    $error("rsflag_bank: WIDTH must be 1..32");
  end
  if (WIDTH > (1 << IDX_W)) begin : g_bad_idx
    $error("rsflag_bank: IDX_W too narrow for WIDTH");
  end

  logic [WIDTH-1:0] flag_q, flag_d;
  logic [WIDTH-1:0] rise_q, rise_d;
  logic [WIDTH-1:0] set_ev, clr_ev;
  logic [WIDTH-1:0] expire;

  // Resolve each channel's request into a set event, a clear event, or neither.
  always_comb begin
    set_ev = '0;
    clr_ev = '0;
    for (int unsigned i = 0; i < WIDTH; i++) begin
      case ({s[i], r[i]})
        2'b10: set_ev[i] = 1'b1;
        2'b01: clr_ev[i] = 1'b1;
        2'b11: begin
          case (COLLISION_MODE)
            0:       clr_ev[i] = 1'b1;
            1:       set_ev[i] = 1'b1;
            2:       begin
              if (flag_q[i]) clr_ev[i] = 1'b1;
              else           set_ev[i] = 1'b1;
            end
            default: ;
          endcase
        end
        default: ;
      endcase
    end
  end

  if (HOLD_CYCLES > 0) begin : g_timer
    localparam int unsigned CW = $clog2(HOLD_CYCLES + 1);
    localparam logic [CW-1:0] RELOAD = CW'(HOLD_CYCLES - 1);

    logic [CW-1:0]    cnt_q [WIDTH];
    logic [CW-1:0]    cnt_d [WIDTH];
    logic [WIDTH-1:0] arm_q, arm_d;

    // arm marks flags set by s; flags loaded by init stay sticky until r.
    always_comb begin
      cnt_d  = cnt_q;
      arm_d  = arm_q;
      expire = '0;
      for (int unsigned i = 0; i < WIDTH; i++) begin
        if (set_ev[i]) begin
          cnt_d[i] = RELOAD;
          arm_d[i] = 1'b1;
        end else if (clr_ev[i]) begin
          cnt_d[i] = '0;
          arm_d[i] = 1'b0;
        end else if (flag_q[i] && arm_q[i]) begin
          if (cnt_q[i] != '0) begin
            cnt_d[i] = cnt_q[i] - 1'b1;
          end else begin
            expire[i] = 1'b1;
            arm_d[i]  = 1'b0;
          end
        end
      end
    end

    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        cnt_q <= '{default: '0};
        arm_q <= '0;
      end else if (init) begin
        cnt_q <= '{default: '0};
        arm_q <= '0;
      end else begin
        cnt_q <= cnt_d;
        arm_q <= arm_d;
      end
    end
  end else begin : g_no_timer
    assign expire = '0;
  end

  always_comb begin
    if (init) begin
      flag_d = INIT_VALUE;
      rise_d = '0;
    end else begin
      flag_d = (flag_q | set_ev) & ~clr_ev & ~expire;
      rise_d = flag_d & ~flag_q;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      flag_q <= '0;
      rise_q <= '0;
    end else begin
      flag_q <= flag_d;
      rise_q <= rise_d;
    end
  end

  always_comb begin
    logic found;
    found     = 1'b0;
    first_idx = '0;
    for (int unsigned i = 0; i < WIDTH; i++) begin
      if (flag_q[i] && !found) begin
        first_idx = IDX_W'(i);
        found     = 1'b1;
      end
    end
  end

  assign q     = flag_q;
  assign rise  = rise_q;
  assign any_q = |flag_q;

`ifdef RSFLAG_BANK_ERR_EN
  logic err_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset)              err_q <= 1'b0;
    else if (init)          err_q <= 1'b0;
    else if (|(s & r))      err_q <= 1'b1;
  end

  assign err = err_q;

`ifndef SYNTHESIS
  always @(posedge clk) begin
    if (!reset && !init) begin
      for (int unsigned i = 0; i < WIDTH; i++) begin
        if (s[i] && r[i]) $display("rsflag_bank: s/r collision on channel %0d", i);
      end
    end
  end
`endif
`endif

endmodule

// File: tb/tb_rsflag_bank.sv
// Directed bench for rsflag_bank: collision modes, init, rise/summary outputs,
// and the hold-timer corner cases on a separate HOLD_CYCLES=4 instance.
module tb_rsflag_bank;

  logic       clk = 1'b0;
  logic       reset;
  logic       init;
  logic [7:0] s, r;
  logic       init4;
  logic [7:0] s4, r4;

  logic [7:0] q0, q1, q2, q3, q4;
  logic [7:0] rise0, rise1, rise2, rise3, rise4;
  logic       any0, any1, any2, any3, any4;
  logic [2:0] idx0, idx1, idx2, idx3, idx4;
`ifdef RSFLAG_BANK_ERR_EN
  logic       err0, err1, err2, err3, err4;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  rsflag_bank #(.WIDTH(8), .INIT_VALUE(8'hA5), .COLLISION_MODE(0), .HOLD_CYCLES(0), .IDX_W(3)) dut0 (
    .clk(clk), .reset(reset), .init(init), .s(s), .r(r),
    .q(q0), .rise(rise0), .any_q(any0), .first_idx(idx0)
`ifdef RSFLAG_BANK_ERR_EN
    , .err(err0)
`endif
  );
  rsflag_bank #(.WIDTH(8), .INIT_VALUE(8'h00), .COLLISION_MODE(1), .HOLD_CYCLES(0), .IDX_W(3)) dut1 (
    .clk(clk), .reset(reset), .init(init), .s(s), .r(r),
    .q(q1), .rise(rise1), .any_q(any1), .first_idx(idx1)
`ifdef RSFLAG_BANK_ERR_EN
    , .err(err1)
`endif
  );
  rsflag_bank #(.WIDTH(8), .INIT_VALUE(8'h00), .COLLISION_MODE(2), .HOLD_CYCLES(0), .IDX_W(3)) dut2 (
    .clk(clk), .reset(reset), .init(init), .s(s), .r(r),
    .q(q2), .rise(rise2), .any_q(any2), .first_idx(idx2)
`ifdef RSFLAG_BANK_ERR_EN
    , .err(err2)
`endif
  );
  rsflag_bank #(.WIDTH(8), .INIT_VALUE(8'h00), .COLLISION_MODE(3), .HOLD_CYCLES(0), .IDX_W(3)) dut3 (
    .clk(clk), .reset(reset), .init(init), .s(s), .r(r),
    .q(q3), .rise(rise3), .any_q(any3), .first_idx(idx3)
`ifdef RSFLAG_BANK_ERR_EN
    , .err(err3)
`endif
  );
  rsflag_bank #(.WIDTH(8), .INIT_VALUE(8'h80), .COLLISION_MODE(0), .HOLD_CYCLES(4), .IDX_W(3)) dut4 (
    .clk(clk), .reset(reset), .init(init4), .s(s4), .r(r4),
    .q(q4), .rise(rise4), .any_q(any4), .first_idx(idx4)
`ifdef RSFLAG_BANK_ERR_EN
    , .err(err4)
`endif
  );

  typedef struct {
    logic       init;
    logic [7:0] s;
    logic [7:0] r;
    logic [7:0] q0;
    logic [7:0] rise0;
    logic       any0;
    logic [2:0] idx0;
    logic [7:0] q1;
    logic [7:0] q2;
    logic [7:0] q3;
    logic       err0;
  } vec_t;

  vec_t vecs[16];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  initial begin
    //          init  s      r      q0     rise0  any idx   q1     q2     q3     err
    vecs[0]  = '{1'b0, 8'h00, 8'h00, 8'h00, 8'h00, 1'b0, 3'd0, 8'h00, 8'h00, 8'h00, 1'b0};
    vecs[1]  = '{1'b0, 8'h00, 8'h00, 8'h00, 8'h00, 1'b0, 3'd0, 8'h00, 8'h00, 8'h00, 1'b0};
    vecs[2]  = '{1'b0, 8'h00, 8'h00, 8'h00, 8'h00, 1'b0, 3'd0, 8'h00, 8'h00, 8'h00, 1'b0};
    vecs[3]  = '{1'b0, 8'h00, 8'h00, 8'h00, 8'h00, 1'b0, 3'd0, 8'h00, 8'h00, 8'h00, 1'b0};
    vecs[4]  = '{1'b0, 8'h00, 8'h00, 8'h00, 8'h00, 1'b0, 3'd0, 8'h00, 8'h00, 8'h00, 1'b0};
    vecs[5]  = '{1'b0, 8'h24, 8'h00, 8'h24, 8'h24, 1'b1, 3'd2, 8'h24, 8'h24, 8'h24, 1'b0};
    vecs[6]  = '{1'b0, 8'h00, 8'h00, 8'h24, 8'h00, 1'b1, 3'd2, 8'h24, 8'h24, 8'h24, 1'b0};
    vecs[7]  = '{1'b0, 8'h00, 8'h04, 8'h20, 8'h00, 1'b1, 3'd5, 8'h20, 8'h20, 8'h20, 1'b0};
    vecs[8]  = '{1'b0, 8'h01, 8'h01, 8'h20, 8'h00, 1'b1, 3'd5, 8'h21, 8'h21, 8'h20, 1'b1};
    vecs[9]  = '{1'b0, 8'h01, 8'h01, 8'h20, 8'h00, 1'b1, 3'd5, 8'h21, 8'h20, 8'h20, 1'b1};
    vecs[10] = '{1'b0, 8'h01, 8'h01, 8'h20, 8'h00, 1'b1, 3'd5, 8'h21, 8'h21, 8'h20, 1'b1};
    vecs[11] = '{1'b0, 8'h0F, 8'hF0, 8'h0F, 8'h0F, 1'b1, 3'd0, 8'h0F, 8'h0F, 8'h0F, 1'b1};
    vecs[12] = '{1'b1, 8'hFF, 8'h00, 8'hA5, 8'h00, 1'b1, 3'd0, 8'h00, 8'h00, 8'h00, 1'b0};
    vecs[13] = '{1'b0, 8'h00, 8'h00, 8'hA5, 8'h00, 1'b1, 3'd0, 8'h00, 8'h00, 8'h00, 1'b0};
    vecs[14] = '{1'b0, 8'h02, 8'h00, 8'hA7, 8'h02, 1'b1, 3'd0, 8'h02, 8'h02, 8'h02, 1'b0};
    vecs[15] = '{1'b0, 8'h00, 8'hFF, 8'h00, 8'h00, 1'b0, 3'd0, 8'h00, 8'h00, 8'h00, 1'b0};

    reset = 1'b1; init = 1'b0; s = '0; r = '0;
    init4 = 1'b0; s4 = '0; r4 = '0;
    #1;
    chk("reset_q0", q0, 8'h00);
    chk("reset_rise0", rise0, 8'h00);
    chk("reset_any0", any0, 1'b0);
    chk("reset_idx0", idx0, 3'd0);
    chk("reset_q4", q4, 8'h00);
    @(posedge clk); #1;
    @(posedge clk); #1;
    reset = 1'b0;

    for (int i = 0; i < 16; i++) begin
      init = vecs[i].init; s = vecs[i].s; r = vecs[i].r;
      @(posedge clk); #1;
      chk($sformatf("v%0d_q0", i), q0, vecs[i].q0);
      chk($sformatf("v%0d_rise0", i), rise0, vecs[i].rise0);
      chk($sformatf("v%0d_any0", i), any0, vecs[i].any0);
      chk($sformatf("v%0d_idx0", i), idx0, vecs[i].idx0);
      chk($sformatf("v%0d_q1", i), q1, vecs[i].q1);
      chk($sformatf("v%0d_q2", i), q2, vecs[i].q2);
      chk($sformatf("v%0d_q3", i), q3, vecs[i].q3);
`ifdef RSFLAG_BANK_ERR_EN
      chk($sformatf("v%0d_err0", i), err0, vecs[i].err0);
`endif
    end
    init = 1'b0; s = '0; r = '0;

    // Single set: high for exactly 4 cycles after the set edge.
    for (int c = 0; c < 7; c++) begin
      s4 = (c == 0) ? 8'h08 : 8'h00;
      @(posedge clk); #1;
      chk($sformatf("hold1_c%0d_q3", c + 1), q4[3], (c + 1 >= 1 && c + 1 <= 4));
      chk($sformatf("hold1_c%0d_rise3", c + 1), rise4[3], (c + 1 == 1));
    end

    // Re-arm at T+3 keeps the flag high through T+7 with a single rise.
    for (int c = 0; c < 10; c++) begin
      s4 = (c == 0 || c == 3) ? 8'h08 : 8'h00;
      @(posedge clk); #1;
      chk($sformatf("hold2_c%0d_q3", c + 1), q4[3], (c + 1 >= 1 && c + 1 <= 7));
      chk($sformatf("hold2_c%0d_rise3", c + 1), rise4[3], (c + 1 == 1));
    end

    // Clear at T+2 drops the flag at T+3 and it stays low.
    for (int c = 0; c < 7; c++) begin
      s4 = (c == 0) ? 8'h08 : 8'h00;
      r4 = (c == 2) ? 8'h08 : 8'h00;
      @(posedge clk); #1;
      chk($sformatf("hold3_c%0d_q3", c + 1), q4[3], (c + 1 >= 1 && c + 1 <= 2));
    end
    s4 = '0; r4 = '0;

    // Flag loaded by init is not timed.
    init4 = 1'b1;
    @(posedge clk); #1;
    init4 = 1'b0;
    chk("init4_q", q4, 8'h80);
    chk("init4_idx", idx4, 3'd7);
    for (int c = 0; c < 8; c++) @(posedge clk);
    #1;
    chk("init4_sticky_q", q4, 8'h80);
    r4 = 8'h80;
    @(posedge clk); #1;
    r4 = '0;
    chk("init4_clear_q", q4, 8'h00);

    // Asynchronous reset in the middle of a hold.
    s4 = 8'h08;
    @(posedge clk); #1;
    s4 = '0;
    chk("midhold_q_before", q4, 8'h08);
    #2;
    reset = 1'b1;
    #1;
    chk("midhold_q_async", q4, 8'h00);
    chk("midhold_rise_async", rise4, 8'h00);
    @(posedge clk); #1;
    reset = 1'b0;
    for (int c = 0; c < 5; c++) begin
      @(posedge clk); #1;
      chk($sformatf("postreset_c%0d_q", c), q4, 8'h00);
      chk($sformatf("postreset_c%0d_rise", c), rise4, 8'h00);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
